// File: rtl/pump_pkg.sv
// Shared types and default constants for the pump-system sensor front-ends.
package pump_pkg;

  // Debounce FSM states of the drain-side sensor conditioner.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } xa_cond_state_t;

  localparam int XA_SYNC_STAGES    = 2;
  localparam int XA_DEB_CYCLES     = 1000;
  localparam int XA_TIMEOUT_CYCLES = 50_000_000;
  localparam int XA_CNT_W          = 16;

endpackage

// File: rtl/sync_ff.sv
// Generic N-stage single-bit synchronizer for asynchronous sensor lines.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw line through the flop chain; the last stage is the safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/xa_sensor_conditioner.sv
// Drain-side sensor front-end: synchronize, debounce, emit one pulse per
// confirmed rising edge, count pulses and flag a sensor that has gone quiet.
module xa_sensor_conditioner
  import pump_pkg::*;
#(
  parameter int SYNC_STAGES    = XA_SYNC_STAGES,
  parameter int DEB_CYCLES     = XA_DEB_CYCLES,
  parameter int TIMEOUT_CYCLES = XA_TIMEOUT_CYCLES,
  parameter int CNT_W          = XA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_in,
  input  logic             en,
  input  logic             clear_fault,
  output logic             level_out,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pulse_count,
  output logic             fault_stuck,
  output xa_cond_state_t   state_dbg
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // The cycle that enters a CHK state already counts as stable cycle 1, so a
  // level is accepted once the counter holds DEB_CYCLES-1 and s_sync is still
  // stable; this gives the k+SYNC_STAGES+DEB_CYCLES-1 latency.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  logic             s_sync;
  xa_cond_state_t   state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             pulse_d, level_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sensor_in),
    .q     (s_sync)
  );

  assign state_dbg = state_q;

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOW;
      deb_q       <= '0;
      level_out   <= 1'b0;
      pulse_out   <= 1'b0;
      pulse_count <= '0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      level_out <= level_d;
      pulse_out <= pulse_d;
      if (pulse_d) begin
        pulse_count <= pulse_count + CNT_W'(1);
      end
    end
  end

  // Next-state logic; disabling drops any pending check back to its stable origin.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    pulse_d = 1'b0;
    if (!en) begin
      deb_d = '0;
      case (state_q)
        RISE_CHK: state_d = LOW;
        FALL_CHK: state_d = HIGH;
        default:  state_d = state_q;
      endcase
    end else begin
      case (state_q)
        LOW: begin
          if (s_sync) begin
            if (DEB_CYCLES == 1) begin
              state_d = HIGH;
              pulse_d = 1'b1;
              deb_d   = '0;
            end else begin
              state_d = RISE_CHK;
              deb_d   = DEB_W'(1);
            end
          end
        end
        RISE_CHK: begin
          if (!s_sync) begin
            state_d = LOW;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d = HIGH;
            pulse_d = 1'b1;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        HIGH: begin
          if (!s_sync) begin
            if (DEB_CYCLES == 1) begin
              state_d = LOW;
              deb_d   = '0;
            end else begin
              state_d = FALL_CHK;
              deb_d   = DEB_W'(1);
            end
          end
        end
        FALL_CHK: begin
          if (s_sync) begin
            state_d = HIGH;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d = LOW;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: begin
          state_d = LOW;
          deb_d   = '0;
        end
      endcase
    end
    level_d = (state_d == HIGH) || (state_d == FALL_CHK);
  end

  // Timeout next value: clear and pulse restart it, disable parks it at 0.
  always_comb begin
    tmo_d = tmo_q;
    if (clear_fault || !en || pulse_d) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter and sticky fault flag; clear beats a simultaneous timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      fault_stuck <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (clear_fault) begin
        fault_stuck <= 1'b0;
      end else if (tmo_d == TMO_MAX) begin
        fault_stuck <= 1'b1;
      end
    end
  end

endmodule
